// File: rtl/wrr_pop_scheduler.sv
// Weighted round-robin pop scheduler: drains four input FIFOs into one shared FIFO.
// Optional macro WRR_STRICT_P0_EN gives port 0 strict priority over ports 1..3.
module wrr_pop_scheduler #(
  parameter int WGT_W = 3
) (
  input  logic               clk,
  input  logic               reset_L,
  input  logic [3:0]         empty,
  input  logic               almost_full,
  input  logic [4*WGT_W-1:0] weight_cfg,
  output logic [3:0]         pop,
  output logic               push,
  output logic [1:0]         mux_sel,
  output logic [1:0]         cur_port,
  output logic               stalled
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SERVE = 2'd1,
    PAUSE = 2'd2
  } state_t;

  state_t           state_r, state_s;
  logic [1:0]       cur_r, cur_s;
  logic [1:0]       ptr_r, ptr_s;
  logic [WGT_W-1:0] burst_cnt_r, burst_cnt_s;
  logic             held_r, held_s;
  logic [3:0]       elig_s;
  logic [2:0]       pick_arb_s;
  logic [2:0]       pick_end_s;
  logic [1:0]       end_ptr_s;
  logic             burst_end_s;

  function automatic logic [WGT_W-1:0] port_wgt(input logic [4*WGT_W-1:0] cfg,
                                                input logic [1:0] idx);
    port_wgt = cfg[int'(idx)*WGT_W +: WGT_W];
  endfunction

  // Returns {found, index} of the first requester scanning start, start+1, ... mod 4.
  function automatic logic [2:0] rr_pick(input logic [3:0] req, input logic [1:0] start);
    logic [1:0] idx;
    rr_pick = 3'b000;
    for (int k = 3; k >= 0; k--) begin
      idx = start + 2'(k);
      if (req[idx]) begin
        rr_pick = {1'b1, idx};
      end else begin
        rr_pick = rr_pick;
      end
    end
  endfunction

  function automatic logic [1:0] onehot_idx(input logic [3:0] oh);
    case (oh)
      4'b0010: onehot_idx = 2'd1;
      4'b0100: onehot_idx = 2'd2;
      4'b1000: onehot_idx = 2'd3;
      default: onehot_idx = 2'd0;
    endcase
  endfunction

  // Eligibility: non-empty and non-zero weight.
  always_comb begin
    elig_s = 4'b0000;
    for (int i = 0; i < 4; i++) begin
      elig_s[i] = ~empty[i] && (weight_cfg[i*WGT_W +: WGT_W] != {WGT_W{1'b0}});
    end
  end

  // Arbitration results for a fresh grant (IDLE/PAUSE) and for a burst end.
  always_comb begin
`ifdef WRR_STRICT_P0_EN
    // Port 0 bypasses ptr; after its own burst it yields once to ports 1..3 if any wait.
    if (cur_r == 2'd0) begin
      end_ptr_s = ptr_r;
    end else if (cur_r == 2'd3) begin
      end_ptr_s = 2'd1;
    end else begin
      end_ptr_s = cur_r + 2'd1;
    end
    if (elig_s[0]) begin
      pick_arb_s = 3'b100;
    end else begin
      pick_arb_s = rr_pick(elig_s, ptr_r);
    end
    if (cur_r == 2'd0) begin
      pick_end_s = rr_pick(elig_s & 4'b1110, end_ptr_s);
      if (!pick_end_s[2]) begin
        pick_end_s = rr_pick(elig_s, end_ptr_s);
      end else begin
        pick_end_s = pick_end_s;
      end
    end else if (elig_s[0]) begin
      pick_end_s = 3'b100;
    end else begin
      pick_end_s = rr_pick(elig_s, end_ptr_s);
    end
`else
    end_ptr_s  = cur_r + 2'd1;
    pick_arb_s = rr_pick(elig_s, ptr_r);
    pick_end_s = rr_pick(elig_s, end_ptr_s);
`endif
  end

  // Pop strobe: only the granted port, gated by state, emptiness and backpressure.
  always_comb begin
    pop = 4'b0000;
    if (state_r == SERVE && !empty[cur_r] && !almost_full) begin
      pop[cur_r] = 1'b1;
    end else begin
      pop = 4'b0000;
    end
  end

  assign burst_end_s = (state_r == SERVE) &&
                       (empty[cur_r] || (pop[cur_r] && burst_cnt_r <= WGT_W'(1)));

  // Next-state logic.
  always_comb begin
    state_s     = state_r;
    cur_s       = cur_r;
    ptr_s       = ptr_r;
    burst_cnt_s = burst_cnt_r;
    held_s      = held_r;
    case (state_r)
      IDLE: begin
        if (pick_arb_s[2] && !almost_full) begin
          cur_s       = pick_arb_s[1:0];
          burst_cnt_s = port_wgt(weight_cfg, pick_arb_s[1:0]);
          held_s      = 1'b1;
          state_s     = SERVE;
        end else if (pick_arb_s[2]) begin
          held_s  = 1'b0;
          state_s = PAUSE;
        end else begin
          state_s = IDLE;
        end
      end
      SERVE: begin
        if (burst_end_s) begin
          ptr_s = end_ptr_s;
          if (pick_end_s[2] && !almost_full) begin
            cur_s       = pick_end_s[1:0];
            burst_cnt_s = port_wgt(weight_cfg, pick_end_s[1:0]);
            held_s      = 1'b1;
            state_s     = SERVE;
          end else if (pick_end_s[2]) begin
            held_s  = 1'b0;
            state_s = PAUSE;
          end else begin
            held_s  = 1'b0;
            state_s = IDLE;
          end
        end else if (almost_full) begin
          state_s = PAUSE;
        end else begin
          burst_cnt_s = burst_cnt_r - WGT_W'(1);
          state_s     = SERVE;
        end
      end
      PAUSE: begin
        if (almost_full) begin
          state_s = PAUSE;
        end else if (held_r) begin
          state_s = SERVE;
        end else if (pick_arb_s[2]) begin
          cur_s       = pick_arb_s[1:0];
          burst_cnt_s = port_wgt(weight_cfg, pick_arb_s[1:0]);
          held_s      = 1'b1;
          state_s     = SERVE;
        end else begin
          state_s = IDLE;
        end
      end
      default: begin
        held_s  = 1'b0;
        state_s = IDLE;
      end
    endcase
  end

  // State, grant and datapath-alignment registers.
  always_ff @(posedge clk or negedge reset_L) begin
    if (!reset_L) begin
      state_r     <= IDLE;
      cur_r       <= 2'd0;
      ptr_r       <= 2'd0;
      burst_cnt_r <= {WGT_W{1'b0}};
      held_r      <= 1'b0;
      push        <= 1'b0;
      mux_sel     <= 2'd0;
      stalled     <= 1'b0;
    end else begin
      state_r     <= state_s;
      cur_r       <= cur_s;
      ptr_r       <= ptr_s;
      burst_cnt_r <= burst_cnt_s;
      held_r      <= held_s;
      push        <= |pop;
      mux_sel     <= (|pop) ? onehot_idx(pop) : mux_sel;
      stalled     <= (state_s == PAUSE);
    end
  end

  assign cur_port = cur_r;

endmodule

// File: tb/tb_wrr_pop_scheduler.sv
// Scoreboard bench for wrr_pop_scheduler: expected pop/stall per cycle queued with stimulus,
// expected push/mux_sel derived from them and checked one cycle later.
module tb_wrr_pop_scheduler;
  localparam int WGT_W = 3;

  logic               clk = 1'b0;
  logic               reset_L;
  logic [3:0]         empty;
  logic               almost_full;
  logic [4*WGT_W-1:0] weight_cfg;
  logic [3:0]         pop;
  logic               push;
  logic [1:0]         mux_sel;
  logic [1:0]         cur_port;
  logic               stalled;

  int         n_tests = 0;
  int         n_fail  = 0;
  string      test_name = "init";
  logic [3:0] exp_pop_q[$];
  logic       exp_st_q[$];
  logic [2:0] exp_push_q[$];
  logic [1:0] sel_hold;

  wrr_pop_scheduler #(.WGT_W(WGT_W)) dut (
    .clk(clk), .reset_L(reset_L), .empty(empty), .almost_full(almost_full),
    .weight_cfg(weight_cfg), .pop(pop), .push(push), .mux_sel(mux_sel),
    .cur_port(cur_port), .stalled(stalled)
  );

  always #5 clk = ~clk;

  task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s/%s: got %0h expected %0h", test_name, tag, got, exp);
    end
  endtask

  function automatic logic [1:0] idx_of(input logic [3:0] p);
    case (p)
      4'b0010: idx_of = 2'd1;
      4'b0100: idx_of = 2'd2;
      4'b1000: idx_of = 2'd3;
      default: idx_of = 2'd0;
    endcase
  endfunction

  task automatic set_w(input int w3, input int w2, input int w1, input int w0);
    weight_cfg = {WGT_W'(w3), WGT_W'(w2), WGT_W'(w1), WGT_W'(w0)};
  endtask

  // One clock cycle: queue expectation, compare at negedge, advance to just past posedge.
  task automatic step(input logic [3:0] p, input logic st);
    logic [2:0] e;
    logic [3:0] ep;
    logic       es;
    exp_pop_q.push_back(p);
    exp_st_q.push_back(st);
    @(negedge clk);
    if (exp_push_q.size() > 0) begin
      e = exp_push_q.pop_front();
      check_val("push", push, e[2]);
      check_val("mux_sel", mux_sel, e[1:0]);
    end
    ep = exp_pop_q.pop_front();
    es = exp_st_q.pop_front();
    check_val("pop", pop, ep);
    check_val("stalled", stalled, es);
    if (ep != 4'b0000) begin
      sel_hold = idx_of(ep);
      exp_push_q.push_back({1'b1, sel_hold});
    end else begin
      exp_push_q.push_back({1'b0, sel_hold});
    end
    @(posedge clk);
    #1;
  endtask

  // Asynchronous reset; outputs must clear before any clock edge.
  task automatic do_reset();
    reset_L = 1'b0;
    #1;
    check_val("rst_pop", pop, 4'b0000);
    check_val("rst_push", push, 1'b0);
    check_val("rst_stalled", stalled, 1'b0);
    check_val("rst_cur_port", cur_port, 2'd0);
    check_val("rst_mux_sel", mux_sel, 2'd0);
    exp_pop_q.delete();
    exp_st_q.delete();
    exp_push_q.delete();
    sel_hold = 2'd0;
    repeat (2) @(posedge clk);
    #1;
    reset_L = 1'b1;
  endtask

  initial begin
    reset_L     = 1'b1;
    empty       = 4'b0000;
    almost_full = 1'b0;
    sel_hold    = 2'd0;
    set_w(1, 1, 1, 1);
    #2;

`ifdef WRR_STRICT_P0_EN
    test_name = "strict_p0";
    set_w(1, 1, 1, 1);
    empty = 4'b0000;
    do_reset();
    step(4'b0000, 1'b0);
    step(4'b0001, 1'b0); step(4'b0010, 1'b0); step(4'b0001, 1'b0); step(4'b0100, 1'b0);
    step(4'b0001, 1'b0); step(4'b1000, 1'b0); step(4'b0001, 1'b0); step(4'b0010, 1'b0);
`else
    test_name = "rr_w1";
    set_w(1, 1, 1, 1);
    do_reset();
    step(4'b0000, 1'b0);
    step(4'b0001, 1'b0); step(4'b0010, 1'b0); step(4'b0100, 1'b0); step(4'b1000, 1'b0);
    step(4'b0001, 1'b0); step(4'b0010, 1'b0);

    test_name = "w_p0_3";
    set_w(1, 1, 1, 3);
    do_reset();
    step(4'b0000, 1'b0);
    repeat (2) begin
      step(4'b0001, 1'b0); step(4'b0001, 1'b0); step(4'b0001, 1'b0);
      step(4'b0010, 1'b0); step(4'b0100, 1'b0); step(4'b1000, 1'b0);
    end

    test_name = "early_end";
    set_w(1, 1, 4, 1);
    do_reset();
    step(4'b0000, 1'b0);
    step(4'b0001, 1'b0); step(4'b0010, 1'b0); step(4'b0010, 1'b0);
    empty = 4'b0010;
    step(4'b0000, 1'b0);
    check_val("cur_after_early", cur_port, 2'd2);
    step(4'b0100, 1'b0); step(4'b1000, 1'b0); step(4'b0001, 1'b0); step(4'b0100, 1'b0);
    empty = 4'b0000;

    test_name = "backpressure";
    set_w(1, 4, 1, 1);
    do_reset();
    step(4'b0000, 1'b0);
    step(4'b0001, 1'b0); step(4'b0010, 1'b0); step(4'b0100, 1'b0); step(4'b0100, 1'b0);
    almost_full = 1'b1;
    step(4'b0000, 1'b0); step(4'b0000, 1'b1); step(4'b0000, 1'b1);
    almost_full = 1'b0;
    step(4'b0000, 1'b1);
    step(4'b0100, 1'b0); step(4'b0100, 1'b0); step(4'b1000, 1'b0); step(4'b0001, 1'b0);

    test_name = "w3_zero";
    set_w(0, 1, 1, 1);
    do_reset();
    step(4'b0000, 1'b0);
    repeat (2) begin
      step(4'b0001, 1'b0); step(4'b0010, 1'b0); step(4'b0100, 1'b0);
    end
`endif

    test_name = "async_reset";
    set_w(1, 1, 1, 4);
    do_reset();
    step(4'b0000, 1'b0);
    step(4'b0001, 1'b0); step(4'b0001, 1'b0);
    check_val("pre_push", push, 1'b1);
    #2;
    do_reset();
    step(4'b0000, 1'b0);
    step(4'b0001, 1'b0);
    almost_full = 1'b1;
    step(4'b0000, 1'b0); step(4'b0000, 1'b1);
    check_val("pre_stalled", stalled, 1'b1);
    #2;
    do_reset();
    almost_full = 1'b0;

    test_name = "random_inv";
    set_w(3, 0, 2, 5);
    do_reset();
    for (int c = 0; c < 300; c++) begin
      empty       = 4'($urandom_range(0, 15));
      almost_full = ($urandom_range(0, 3) == 0);
      @(negedge clk);
      check_val("onehot", $onehot0(pop), 1'b1);
      check_val("pop_empty", |(pop & empty), 1'b0);
      check_val("pop_af", (|pop) & almost_full, 1'b0);
      check_val("pop_w0", pop[2], 1'b0);
      @(posedge clk);
      #1;
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
